serial_alu_sequencer: RTL and testbench

Multi-cycle bit-serial arithmetic unit that time-shares one 1-bit FullAdder cell (inputs A, B, C; outputs SUM, CARRY) to perform WIDTH-bit ADD, SUB and MUL. It sits beside the single-cycle ALU in the 8-bit processor as a low-area arithmetic option. The control unit raises START with operands, holds the PC on BUSY and writes RESULT back on the DONE pulse.

---
 rtl/serial_alu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_serial_alu_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: bit-serial ADD/SUB/MUL built around one time-shared
// full-adder cell. ADD/SUB take WIDTH cycles and MUL takes WIDTH*WIDTH cycles.
// Results are committed on the edge that leaves FINISH.

module serial_alu_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] addend_q, addend_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             carry_q,  carry_d;
  logic             sub_q,    sub_d;
  logic             mul_q,    mul_d;
  logic [CW-1:0]    bit_q,    bit_d;
  logic [CW-1:0]    pass_q,   pass_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             zero_q,   zero_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic [WIDTH-1:0] acc_step;
  logic             bit_wrap;

  // Shared full-adder cell; the sub flag inverts the addend bit for two's-complement subtract
  always_comb begin
    fa_a    = acc_q[0];
    fa_b    = addend_q[0] ^ sub_q;
    fa_cin  = carry_q;
    fa_sum  = fa_a ^ fa_b ^ fa_cin;
    fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  end

  assign acc_step = {fa_sum, acc_q[WIDTH-1:1]};
  assign bit_wrap = (bit_q == CNT_LAST);

  // Next-state and datapath update: capture in IDLE, serial step in RUN/FINISH, commit in FINISH
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    addend_d = addend_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    mul_d    = mul_q;
    bit_d    = bit_q;
    pass_d   = pass_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && (op_i != OP_RSV)) begin
          sub_d    = (op_i == OP_SUB);
          mul_d    = (op_i == OP_MUL);
          carry_d  = (op_i == OP_SUB);
          mcand_d  = data1_i;
          // Multiplier bit 0 is consumed now; the register holds the bits for later passes
          mplier_d = data2_i >> 1;
          if (op_i == OP_MUL) begin
            acc_d    = '0;
            addend_d = data2_i[0] ? data1_i : '0;
          end else begin
            acc_d    = data1_i;
            addend_d = data2_i;
          end
          bit_d   = '0;
          pass_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_FINISH: begin
        acc_d    = acc_step;
        addend_d = addend_q >> 1;
        carry_d  = fa_cout;
        if (bit_wrap) begin
          bit_d  = '0;
          pass_d = pass_q + CW'(1);
          // Pass boundary in MUL: reload the next shifted partial product, drop inter-pass carry
          if (mul_q) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            addend_d = mplier_q[0] ? (mcand_q << 1) : '0;
            carry_d  = 1'b0;
          end
        end else begin
          bit_d = bit_q + CW'(1);
        end

        if (state_q == ST_RUN) begin
          // Enter FINISH when the upcoming step is the final bit of the final pass
          if ((bit_d == CNT_LAST) && (!mul_q || (pass_d == CNT_LAST))) begin
            state_d = ST_FINISH;
          end
        end else begin
          result_d = acc_step;
          cout_d   = mul_q ? 1'b0 : fa_cout;
          zero_d   = (acc_step == '0);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          bit_d    = '0;
          pass_d   = '0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      addend_q <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      mul_q    <= 1'b0;
      bit_q    <= '0;
      pass_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      addend_q <= addend_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      mul_q    <= mul_d;
      bit_q    <= bit_d;
      pass_q   <= pass_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result_o    = result_q;
  assign carry_out_o = cout_q;
  assign zero_o      = zero_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Testbench for serial_alu_sequencer: directed cases plus random operations
// checked against an arithmetic reference model.

module tb_serial_alu_sequencer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] d1, d2;
  logic [W-1:0] result;
  logic         cout, zero, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] last_exp;

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .op_i        (op),
    .data1_i     (d1),
    .data2_i     (d2),
    .result_o    (result),
    .carry_out_o (cout),
    .zero_o      (zero),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference arithmetic: plain integer math on the operands
  task automatic model(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c, output logic z, output int lat);
    int unsigned ia, ib, t;
    ia = a;
    ib = b;
    case (mop)
      2'b00: begin t = ia + ib; r = t[W-1:0]; c = (t >= 256); lat = W; end
      2'b01: begin t = (ia + 256 - ib); r = t[W-1:0]; c = (ia >= ib); lat = W; end
      default: begin t = ia * ib; r = t[W-1:0]; c = 1'b0; lat = W * W; end
    endcase
    z = (r == 0);
  endtask

  task automatic run_op(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    logic [W-1:0] er;
    logic ec, ez;
    int lat, cnt;
    bit busy_ok;
    model(mop, a, b, er, ec, ez, lat);
    start = 1'b1; op = mop; d1 = a; d2 = b;
    tick();
    start = 1'b0;
    check({tag, " busy_rise"}, 32'(busy), 32'd1);
    cnt = 0;
    busy_ok = 1'b1;
    while (cnt < 200) begin
      tick();
      cnt++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, " latency"}, 32'(cnt), 32'(lat));
    check({tag, " result"}, 32'(result), 32'(er));
    check({tag, " carry"}, 32'(cout), 32'(ec));
    check({tag, " zero"}, 32'(zero), 32'(ez));
    check({tag, " busy_fall"}, 32'(busy), 32'd0);
    check({tag, " busy_held"}, 32'(busy_ok), 32'd1);
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    last_exp = er;
  endtask

  initial begin
    int cnt, prev, ndone, extra;
    logic any;
    reset = 1'b1; start = 1'b1; op = 2'b00; d1 = 8'hAA; d2 = 8'h55;
    tick();
    tick();
    check("reset_state", {23'd0, result, cout, zero, busy, done}, 32'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("idle_after_reset", {30'd0, busy, done}, 32'd0);

    run_op(2'b00, 8'h2D, 8'h17, "add_2d_17");
    run_op(2'b00, 8'hFF, 8'h01, "add_ff_01");
    run_op(2'b01, 8'h10, 8'h20, "sub_10_20");
    run_op(2'b01, 8'h20, 8'h20, "sub_20_20");
    run_op(2'b10, 8'h0D, 8'h0B, "mul_0d_0b");
    run_op(2'b10, 8'h20, 8'h10, "mul_20_10");
    run_op(2'b10, 8'hFF, 8'hFF, "mul_ff_ff");

    // Inputs changing while busy are ignored
    start = 1'b1; op = 2'b00; d1 = 8'h11; d2 = 8'h22;
    tick();
    start = 1'b0;
    tick();
    tick();
    op = 2'b10; d1 = 8'hFF; d2 = 8'h7E; start = 1'b1;
    tick();
    start = 1'b0; op = 2'b01; d1 = 8'h03;
    cnt = 3;
    while (cnt < 200) begin
      if (done) break;
      tick();
      cnt++;
    end
    check("busy_ignore latency", 32'(cnt), 32'd8);
    check("busy_ignore result", 32'(result), 32'h33);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) extra++;
    end
    check("busy_ignore single_done", 32'(extra), 32'd0);
    last_exp = 8'h33;

    // Reserved opcode is ignored
    start = 1'b1; op = 2'b11; d1 = 8'h12; d2 = 8'h34;
    tick();
    start = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy || done) any = 1'b1;
      tick();
    end
    check("rsv_op no_activity", 32'(any), 32'd0);
    check("rsv_op result_held", 32'(result), 32'(last_exp));

    // START held high: back-to-back ADDs every WIDTH+1 cycles
    start = 1'b1; op = 2'b00; d1 = 8'h01; d2 = 8'h01;
    tick();
    prev = -1;
    ndone = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (done) begin
        check("held_start result", 32'(result), 32'h02);
        if (prev >= 0) check("held_start period", 32'(c - prev), 32'd9);
        prev = c;
        ndone++;
        if (ndone == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    check("held_start done_count", 32'(ndone), 32'd3);
    tick();
    check("held_start stop", 32'(busy), 32'd0);

    // Reset on the 4th RUN cycle of a MUL discards it
    start = 1'b1; op = 2'b10; d1 = 8'h5A; d2 = 8'h33;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mid_reset outputs", {23'd0, result, cout, zero, busy, done}, 32'd0);
    reset = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (busy || done) any = 1'b1;
    end
    check("mid_reset no_done", 32'(any), 32'd0);
    run_op(2'b00, 8'h05, 8'h03, "post_reset_add");

    // Random operations against the model
    for (int i = 0; i < 24; i++) begin
      logic [1:0] rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 2));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (i % 6 == 0) rb = ra;
      run_op(rop, ra, rb, $sformatf("rand%0d op%0d %02h_%02h", i, rop, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
